// File: rtl/uart_tx_periph_if.sv
// Peripheral-bus bundle between the memory stage (master) and uart_tx_periph (slave).
// rd/wr are single-cycle strobes already qualified by address decode; rdata is combinational.
interface uart_tx_periph_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, output wr, output addr, output wdata, input rdata);
  modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: TX FIFO, 8N1 framing, programmable baud divider, level irq.
// Optional parity bit (CTRL[1] enable, CTRL[2] odd) when UART_TX_PARITY_EN is defined.
module uart_tx_periph #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_RESET  = 217
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_tx_periph_if.slave        bus,
  output logic                   UART_TX,
  output logic                   irqout,
  output logic [2:0]             dbg_state
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;
`endif

  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          irq_en_q, irq_en_d;
  logic          par_en_q, par_en_d;
  logic          par_odd_q, par_odd_d;
  logic [15:0]   div_q, div_d;
  logic [2:0]    state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   cur_div_q, cur_div_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          irq_q, irq_d;

  logic [1:0]  sel;
  logic        wr_txdata, wr_ctrl, wr_div, rd_status;
  logic        empty, full, busy, pop, push, ovf_set, bit_end;
  logic [31:0] status_w;
  logic        unused_bus;

  always_comb begin
    sel       = bus.addr[3:2];
    wr_txdata = bus.wr && (sel == 2'd0);
    wr_ctrl   = bus.wr && (sel == 2'd2);
    wr_div    = bus.wr && (sel == 2'd3);
    rd_status = bus.rd && (sel == 2'd1);
    empty     = (count_q == '0);
    full      = (count_q == DEPTH_C);
    busy      = (state_q != ST_IDLE) || !empty;
  end

  assign unused_bus = ^{bus.addr[31:4], bus.addr[1:0], bus.wdata[31:16]};

  // Bit timer: cur_div is latched at every bit boundary so BAUDDIV writes never stretch a bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_div_d = cur_div_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    bit_end   = (cnt_q == cur_div_q - 16'd1);
    if (state_q == ST_IDLE) begin
      tx_d = 1'b1;
      if (!empty) begin
        pop       = 1'b1;
        shreg_d   = fifo_mem_q[rptr_q];
        state_d   = ST_START;
        cnt_d     = 16'd0;
        cur_div_d = div_q;
        tx_d      = 1'b0;
      end
    end else if (!bit_end) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d     = 16'd0;
      cur_div_d = div_q;
      case (state_q)
        ST_START: begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
          tx_d      = shreg_q[0];
        end
        ST_DATA: begin
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = (^shreg_q) ^ par_odd_q;
            end
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shreg_q[bit_idx_q + 3'd1];
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
`endif
        default: begin
          // End of stop bit: chain straight into the next frame when data is waiting.
          if (!empty) begin
            pop     = 1'b1;
            shreg_d = fifo_mem_q[rptr_q];
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      endcase
    end
  end

  // A pop in the same cycle frees the slot, so a write to a full FIFO is then accepted.
  always_comb begin
    push    = wr_txdata && (!full || pop);
    ovf_set = wr_txdata && full && !pop;
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
    ovf_d   = ovf_set ? 1'b1 : (rd_status ? 1'b0 : ovf_q);
  end

  always_comb begin
    irq_en_d  = wr_ctrl ? bus.wdata[0] : irq_en_q;
    par_en_d  = 1'b0;
    par_odd_d = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d  = wr_ctrl ? bus.wdata[1] : par_en_q;
    par_odd_d = wr_ctrl ? bus.wdata[2] : par_odd_q;
`endif
    div_d = div_q;
    if (wr_div) div_d = (bus.wdata[15:0] < 16'd2) ? 16'd2 : bus.wdata[15:0];
    // Requiring IDLE both now and next keeps irq low across the IDLE->START pop cycle.
    irq_d = irq_en_d && (count_d == '0) && (state_q == ST_IDLE) && (state_d == ST_IDLE);
  end

  always_comb begin
    status_w         = 32'd0;
    status_w[0]      = busy;
    status_w[1]      = full;
    status_w[2]      = empty;
    status_w[3]      = ovf_q;
    status_w[8 +: CW] = count_q;
    bus.rdata = 32'd0;
    if (bus.rd) begin
      case (sel)
        2'd1:    bus.rdata = status_w;
        2'd2:    bus.rdata = {29'd0, par_odd_q, par_en_q, irq_en_q};
        2'd3:    bus.rdata = {16'd0, div_q};
        default: bus.rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wptr_q] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      div_q     <= 16'(DIV_RESET);
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      cur_div_q <= 16'(DIV_RESET);
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'd0;
      tx_q      <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      irq_en_q  <= irq_en_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      div_q     <= div_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_div_q <= cur_div_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      irq_q     <= irq_d;
    end
  end

  assign UART_TX   = tx_q;
  assign irqout    = irq_q;
  assign dbg_state = state_q;
endmodule
